// File: rtl/mux2x1_arb_if.sv
// mux2x1_arb_if: source/output handshakes, mux select and debug counters of the arbiter
interface mux2x1_arb_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             sel;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  modport master (
    output a_data, a_valid, b_data, b_valid, out_ready,
    input  a_ready, b_ready, out_data, out_valid, sel, cnt_a, cnt_b
  );
  modport slave (
    input  a_data, a_valid, b_data, b_valid, out_ready,
    output a_ready, b_ready, out_data, out_valid, sel, cnt_a, cnt_b
  );
endinterface

// File: rtl/mux2x1_arb.sv
// mux2x1_arb: burst-limited round-robin arbiter for two sources feeding a registered 2:1 mux output
module mux2x1_arb #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 8
) (
  input logic           clk,
  input logic           rst_n,
  mux2x1_arb_if.slave   bus
);
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_q, sel_d;
  logic [3:0]       burst_q, burst_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic             load, gnt_v, gnt_b, xfer;
  // Grant decision, readies (held low in reset) and next state of the output stage
  always_comb begin
    load        = !out_valid_q || bus.out_ready;
    gnt_v       = bus.a_valid || bus.b_valid;
    gnt_b       = (bus.a_valid && bus.b_valid) ? ((burst_q < 4'(MAX_BURST)) ? sel_q : !sel_q) : bus.b_valid;
    xfer        = rst_n && load && gnt_v;
    out_data_d  = xfer ? (gnt_b ? bus.b_data : bus.a_data) : out_data_q;
    out_valid_d = xfer || (out_valid_q && !bus.out_ready);
    sel_d       = xfer ? gnt_b : sel_q;
    burst_d     = !xfer ? burst_q : (gnt_b != sel_q) ? 4'd1 : (burst_q == 4'hf) ? burst_q : burst_q + 4'd1;
    cnt_a_d     = cnt_a_q + CNT_W'(xfer && !gnt_b);
    cnt_b_d     = cnt_b_q + CNT_W'(xfer && gnt_b);
  end
  // Output register, arbitration history and transfer counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sel_q       <= 1'b0;
      burst_q     <= '0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sel_q       <= sel_d;
      burst_q     <= burst_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
    end
  end
  assign bus.a_ready   = xfer && !gnt_b;
  assign bus.b_ready   = xfer && gnt_b;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel       = sel_q;
  assign bus.cnt_a     = cnt_a_q;
  assign bus.cnt_b     = cnt_b_q;
endmodule

// File: tb/tb_mux2x1_arb.sv
// tb_mux2x1_arb: scoreboard bench for the burst-limited two-source arbiter
module tb_mux2x1_arb;
  localparam int MB = 4;
  typedef struct packed {
    logic [7:0] d;
    logic       s;
  } exp_t;
  logic clk;
  logic rst_n;
  int   asserts;
  int   fails;
  exp_t sb[$];
  logic [7:0] a_d, b_d;
  mux2x1_arb_if #(.WIDTH(8), .CNT_W(8)) bus ();
  mux2x1_arb_if #(.WIDTH(8), .CNT_W(2)) bus2 ();
  mux2x1_arb #(.WIDTH(8), .MAX_BURST(MB), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  mux2x1_arb #(.WIDTH(8), .MAX_BURST(MB), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // Output-side scoreboard: every word leaving the DUT must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      asserts++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got data=%h sel=%b, expected no word", bus.out_data, bus.sel);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({bus.out_data, bus.sel} !== e) begin
          fails++;
          $display("FAIL sb_word: got data=%h sel=%b, expected data=%h sel=%b", bus.out_data, bus.sel, e.d, e.s);
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.a_valid = 0; bus.b_valid = 0; bus.out_ready = 1; bus.a_data = 0; bus.b_data = 0;
    bus2.a_valid = 0; bus2.b_valid = 0; bus2.out_ready = 1; bus2.a_data = 0; bus2.b_data = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    sb.delete();
    a_d = 8'ha0;
    b_d = 8'hb0;
  endtask
  task automatic drain(string name);
    bus.a_valid = 0; bus.b_valid = 0; bus.out_ready = 1;
    repeat (2) tick();
    asserts++;
    if (sb.size() !== 0) begin
      fails++;
      $display("FAIL %s_drain: %0d words still expected, expected 0", name, sb.size());
    end
  endtask
  // Both sources valid from a fresh arbitration state: n words, MB from each in turn
  task automatic run_both(int n);
    bus.a_valid = 1; bus.b_valid = 1; bus.out_ready = 1;
    for (int i = 0; i < n; i++) begin
      logic src;
      src = ((i / MB) % 2) == 1;
      bus.a_data = a_d;
      bus.b_data = b_d;
      #1;
      asserts++;
      if ({bus.a_ready, bus.b_ready} !== {!src, src}) begin
        fails++;
        $display("FAIL both_ready[%0d]: got a=%b b=%b, expected a=%b b=%b", i, bus.a_ready, bus.b_ready, !src, src);
      end
      sb.push_back(exp_t'{src ? b_d : a_d, src});
      if (src) b_d++; else a_d++;
      tick();
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    bus.a_valid = 1; bus.b_valid = 1; bus.out_ready = 1; bus.a_data = 8'h77; bus.b_data = 8'h88;
    repeat (3) tick();
    asserts++;
    if ({bus.out_valid, bus.sel, bus.a_ready, bus.b_ready, bus.cnt_a, bus.cnt_b} !== 20'h0) begin
      fails++;
      $display("FAIL reset_state: got v=%b sel=%b ar=%b br=%b ca=%h cb=%h, expected all 0",
               bus.out_valid, bus.sel, bus.a_ready, bus.b_ready, bus.cnt_a, bus.cnt_b);
    end
    rst_n = 1'b1;
    #1;
    asserts++;
    if ({bus.a_ready, bus.b_ready} !== 2'b10) begin
      fails++;
      $display("FAIL reset_first_grant: got a=%b b=%b, expected a=1 b=0", bus.a_ready, bus.b_ready);
    end
    sb.push_back(exp_t'{8'h77, 1'b0});
    tick();
    drain("reset");
  endtask
  task automatic test_single();
    logic [7:0] w[3] = '{8'h11, 8'h12, 8'h13};
    do_reset();
    bus.b_valid = 0; bus.out_ready = 1; bus.a_valid = 1;
    for (int i = 0; i < 3; i++) begin
      bus.a_data = w[i];
      #1;
      asserts++;
      if (bus.a_ready !== 1'b1) begin
        fails++;
        $display("FAIL single_ready[%0d]: got %b, expected 1", i, bus.a_ready);
      end
      sb.push_back(exp_t'{w[i], 1'b0});
      tick();
      asserts++;
      if ({bus.out_valid, bus.out_data, bus.sel} !== {1'b1, w[i], 1'b0}) begin
        fails++;
        $display("FAIL single_latency[%0d]: got v=%b d=%h sel=%b, expected v=1 d=%h sel=0",
                 i, bus.out_valid, bus.out_data, bus.sel, w[i]);
      end
    end
    bus.a_valid = 0;
    tick();
    asserts++;
    if (bus.cnt_a !== 8'd3 || bus.cnt_b !== 8'd0) begin
      fails++;
      $display("FAIL single_cnt: got cnt_a=%0d cnt_b=%0d, expected 3 0", bus.cnt_a, bus.cnt_b);
    end
    drain("single");
  endtask
  task automatic test_burst();
    do_reset();
    run_both(8);
    asserts++;
    if (bus.cnt_a !== 8'd4 || bus.cnt_b !== 8'd4) begin
      fails++;
      $display("FAIL burst_cnt: got cnt_a=%0d cnt_b=%0d, expected 4 4", bus.cnt_a, bus.cnt_b);
    end
    bus.a_data = a_d;
    #1;
    asserts++;
    if ({bus.a_ready, bus.b_ready} !== 2'b10) begin
      fails++;
      $display("FAIL burst_wrap_to_a: got a=%b b=%b, expected a=1 b=0", bus.a_ready, bus.b_ready);
    end
    sb.push_back(exp_t'{a_d, 1'b0});
    tick();
    drain("burst");
  endtask
  task automatic test_back_to_back();
    do_reset();
    bus.a_valid = 1; bus.b_valid = 0; bus.out_ready = 1; bus.a_data = 8'h5a;
    sb.push_back(exp_t'{8'h5a, 1'b0});
    tick();
    bus.out_ready = 0; bus.a_data = 8'h5b; bus.b_valid = 1; bus.b_data = 8'hc3;
    for (int i = 0; i < 5; i++) begin
      #1;
      asserts++;
      if ({bus.out_valid, bus.out_data, bus.a_ready, bus.b_ready, bus.cnt_a, bus.cnt_b} !== {1'b1, 8'h5a, 2'b00, 8'd1, 8'd0}) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h ar=%b br=%b ca=%0d cb=%0d, expected v=1 d=5a ar=0 br=0 ca=1 cb=0",
                 i, bus.out_valid, bus.out_data, bus.a_ready, bus.b_ready, bus.cnt_a, bus.cnt_b);
      end
      tick();
    end
    bus.out_ready = 1;
    #1;
    asserts++;
    if ({bus.a_ready, bus.b_ready} !== 2'b10) begin
      fails++;
      $display("FAIL bp_release_ready: got a=%b b=%b, expected a=1 b=0", bus.a_ready, bus.b_ready);
    end
    sb.push_back(exp_t'{8'h5b, 1'b0});
    tick();
    asserts++;
    if ({bus.out_valid, bus.out_data} !== {1'b1, 8'h5b}) begin
      fails++;
      $display("FAIL bp_no_bubble: got v=%b d=%h, expected v=1 d=5b", bus.out_valid, bus.out_data);
    end
    drain("bp");
  endtask
  task automatic test_cnt_wrap();
    logic [1:0] exp_c[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    bus2.a_valid = 1; bus2.out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      bus2.a_data = 8'(i);
      tick();
      asserts++;
      if (bus2.cnt_a !== exp_c[i]) begin
        fails++;
        $display("FAIL wrap_cnt[%0d]: got %0d, expected %0d", i, bus2.cnt_a, exp_c[i]);
      end
    end
    bus2.a_valid = 0;
    tick();
  endtask
  task automatic test_reset_mid();
    do_reset();
    run_both(6);
    #2;
    rst_n = 1'b0;
    #1;
    asserts++;
    if ({bus.out_valid, bus.sel, bus.a_ready, bus.b_ready} !== 4'b0000) begin
      fails++;
      $display("FAIL mid_reset_async: got v=%b sel=%b ar=%b br=%b, expected all 0",
               bus.out_valid, bus.sel, bus.a_ready, bus.b_ready);
    end
    sb.delete();
    tick();
    rst_n = 1'b1;
    run_both(5);
    drain("mid");
  endtask
  initial begin
    asserts = 0;
    fails = 0;
    test_reset();
    test_single();
    test_burst();
    test_back_to_back();
    test_cnt_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/mux2x1_arb.md
Name: mux2x1_arb

Overview:
- Registered two-source arbiter that sits directly upstream of the team's 2:1 multiplexer.
- Accepts data from sources A and B over valid/ready handshakes and chooses which source is served with a bounded round-robin (burst-limited) policy.
- Drives `sel` for the downstream mux and presents the chosen word on a registered output with its own valid/ready handshake.
- Keeps per-source transfer counters for debug and bench checking.

Parameters:
- WIDTH, 8: data width of each source and of the output.
- MAX_BURST, 4: maximum consecutive grants to one source while the other source is waiting. Legal range is 1..15; a value of 1 gives strict alternation.
- CNT_W, 8: width of the per-source transfer counters. The counters wrap modulo 2^CNT_W.

Ports:
- clk  input  1  single rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- a_data  input  WIDTH  source A data.
- a_valid  input  1  source A holds a valid word.
- a_ready  output  1  source A word is accepted this cycle.
- b_data  input  WIDTH  source B data.
- b_valid  input  1  source B holds a valid word.
- b_ready  output  1  source B word is accepted this cycle.
- out_data  output  WIDTH  registered selected word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- sel  output  1  source of the word in out_data: 0 = A, 1 = B. Wired to the mux select.
- cnt_a  output  CNT_W  completed input transfers from A.
- cnt_b  output  CNT_W  completed input transfers from B.

Behaviour:
- Reset (asynchronous, on rst_n low):
  - out_valid=0, out_data=0, sel=0, burst_cnt=0, cnt_a=0, cnt_b=0.
  - a_ready and b_ready read 0 while rst_n is low.
  - Asserting rst_n mid-transfer discards the held word; no partial state survives.
- Load condition: `load = !out_valid || out_ready`. The output register accepts a new word only when load=1.
- Grant decision, combinational, evaluated each cycle:
  - Neither source valid: no grant.
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid and burst_cnt < MAX_BURST: grant the current sel.
  - Both valid and burst_cnt >= MAX_BURST: grant the other source.
- Ready outputs:
  - a_ready = load && grant==A; b_ready = load && grant==B.
  - At most one ready is high per cycle.
  - Ready does not depend on the source's own valid beyond the grant decision; no combinational loop to the sources.
- Input transfer: occurs when x_valid && x_ready. On the next rising edge:
  - out_data <= x_data; out_valid <= 1; sel <= granted source.
  - If the granted source equals the previous sel, burst_cnt <= burst_cnt+1, saturating at 15; otherwise burst_cnt <= 1.
  - cnt_x <= cnt_x+1, wrapping from 2^CNT_W-1 to 0.
- Output transfer: occurs when out_valid && out_ready with no input transfer in the same cycle; out_valid <= 0 on the next edge.
- Simultaneous output and input transfer: out_valid stays 1, new data is loaded, and full throughput of one word per cycle is sustained.
- Backpressure: while out_valid=1 and out_ready=0:
  - out_data, sel, out_valid and the counters are frozen.
  - Both readies are 0.
- sel and burst_cnt hold their values while idle, so the round-robin history is preserved across gaps.
- Latency: one cycle from input acceptance to out_valid.
- sel changes only together with a new out_data load, so the downstream mux select is glitch-free relative to the data.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles with a_valid=b_valid=1 -> out_valid=0, sel=0, a_ready=b_ready=0, cnt_a=cnt_b=0. After release, the first accepted word comes from A.
- Single source: a_valid=1, a_data=0x11, 0x12, 0x13, b_valid=0, out_ready=1 -> out_data 0x11, 0x12, 0x13 on consecutive cycles, one cycle after acceptance; sel=0; cnt_a=3.
- Burst limit: MAX_BURST=4, both valid continuously, out_ready=1 -> sel sequence 0,0,0,0,1,1,1,1,0..., i.e. A,A,A,A,B,B,B,B,A. After 8 output words, cnt_a=4 and cnt_b=4.
- Backpressure: out_valid=1 with out_data=0x5A; hold out_ready=0 for 5 cycles -> out_data stays 0x5A, a_ready=b_ready=0, counters unchanged. With out_ready=1, the next word loads on the following edge with no bubble.
- Counter wrap: CNT_W=2, 5 A transfers -> cnt_a goes 1,2,3,0,1.
- Reset mid-stream: assert rst_n=0 asynchronously between edges during the both-valid alternation -> out_valid=0 and sel=0 immediately; after release, arbitration restarts at A with burst_cnt=0.
